// File: rtl/fp_addsub_arb_if.sv
// Requester, shared-FPU and response signal bundle for fp_addsub_arb.
// slave = arbiter side, master = environment (requesters, FPU, consumer).
interface fp_addsub_arb_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) ();
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [32*N_REQ-1:0]    req_a;
    logic [32*N_REQ-1:0]    req_b;
    logic [N_REQ-1:0]       req_sub;
    logic [31:0]            fpu_a;
    logic [31:0]            fpu_b;
    logic                   fpu_sub;
    logic [31:0]            fpu_z;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [31:0]            rsp_z;
    logic [ID_W-1:0]        rsp_id;
    logic [CNT_W*N_REQ-1:0] grant_cnt;

    modport slave (
        input  req_valid, req_a, req_b, req_sub, fpu_z, rsp_ready,
        output req_ready, fpu_a, fpu_b, fpu_sub, rsp_valid, rsp_z, rsp_id, grant_cnt
    );

    modport master (
        output req_valid, req_a, req_b, req_sub, fpu_z, rsp_ready,
        input  req_ready, fpu_a, fpu_b, fpu_sub, rsp_valid, rsp_z, rsp_id, grant_cnt
    );
endinterface

// File: rtl/fp_addsub_arb.sv
// Round-robin sharing of one combinational FP add/sub unit: operand register -> FPU -> result register.
// Define FP_ADDSUB_ARB_STATS_EN to get saturating per-requester grant counters on grant_cnt.
module fp_addsub_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    fp_addsub_arb_if.slave bus
);

    // S1 operand register
    logic            op_vld_q, op_vld_d;
    logic [31:0]     op_a_q, op_a_d;
    logic [31:0]     op_b_q, op_b_d;
    logic            op_sub_q, op_sub_d;
    logic [ID_W-1:0] op_id_q, op_id_d;
    // S2 result register
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_z_q, rsp_z_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic            s2_free, s1_free, s1_adv;
    logic            found, accept;
    logic [ID_W-1:0] gnt_idx;
    logic [N_REQ-1:0] req_ready_c;

    function automatic logic [ID_W-1:0] slot_at(input logic [ID_W-1:0] base, input int k);
        int idx;
        idx = int'(base) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        return idx[ID_W-1:0];
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        s2_free = !rsp_valid_q || bus.rsp_ready;
        s1_adv  = op_vld_q && s2_free;
        s1_free = !op_vld_q || s2_free;

        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && bus.req_valid[slot_at(rr_ptr_q, k)]) begin
                found   = 1'b1;
                gnt_idx = slot_at(rr_ptr_q, k);
            end
        end
        accept = s1_free && found;

        req_ready_c = '0;
        op_vld_d    = op_vld_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_sub_d    = op_sub_q;
        op_id_d     = op_id_q;
        rr_ptr_d    = rr_ptr_q;

        if (accept) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt_idx == ID_W'(i)) begin
                    req_ready_c[i] = 1'b1;
                    op_a_d         = bus.req_a[32*i +: 32];
                    op_b_d         = bus.req_b[32*i +: 32];
                    op_sub_d       = bus.req_sub[i];
                end
            end
            op_vld_d = 1'b1;
            op_id_d  = gnt_idx;
            rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end else if (s1_adv) begin
            op_vld_d = 1'b0;
        end

        rsp_valid_d = rsp_valid_q;
        rsp_z_d     = rsp_z_q;
        rsp_id_d    = rsp_id_q;
        if (s1_adv) begin
            rsp_valid_d = 1'b1;
            rsp_z_d     = bus.fpu_z;
            rsp_id_d    = op_id_q;
        end else if (s2_free) begin
            rsp_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_vld_q    <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_sub_q    <= 1'b0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_z_q     <= '0;
            rsp_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            op_vld_q    <= op_vld_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_sub_q    <= op_sub_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_z_q     <= rsp_z_d;
            rsp_id_q    <= rsp_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.fpu_a     = op_a_q;
    assign bus.fpu_b     = op_b_q;
    assign bus.fpu_sub   = op_sub_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_z     = rsp_z_q;
    assign bus.rsp_id    = rsp_id_q;

`ifdef FP_ADDSUB_ARB_STATS_EN
    logic [N_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (accept && gnt_idx == ID_W'(i) && !(&cnt_q[i])) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.grant_cnt = cnt_q;
`else
    assign bus.grant_cnt = {(CNT_W*N_REQ){1'b0}};
`endif

endmodule
